multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
- Parametrised successor to the single-configuration 32x32 two-read-port register file.
- Configurable width and depth, NUM_READ independent read ports with per-port enable, optional hardwired-zero register 0.
- Adds a per-register pending-write scoreboard (busy bits plus busy count) so issue logic can detect RAW hazards before a long-latency result is written back.
- Sits between decode/issue and writeback in the pipelined datapath.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; need not be a power of two.
- ADDR_W, 5, address bits; must satisfy 2^ADDR_W >= DEPTH.
- NUM_READ, 2, number of read ports (1..8).
- ZERO_REG, 1, when 1, register 0 always reads 0 and can never be written or reserved.

Ports:
- Clk  in  1  single clock; writes and reservations on the rising edge, read capture on the falling edge.
- Reset_n  in  1  asynchronous, active-low reset.
- RegWrite  in  1  write enable, sampled at posedge Clk.
- WriteRegister  in  ADDR_W  write address.
- WriteData  in  WIDTH  write data.
- Reserve  in  1  mark a register as pending write, sampled at posedge Clk.
- ReserveRegister  in  ADDR_W  address to reserve.
- ReadRegister  in  NUM_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- ReadEnable  in  NUM_READ  per-port capture enable.
- ReadData  out  NUM_READ*WIDTH  packed registered read data; port k uses bits [k*WIDTH +: WIDTH].
- ReadBusy  out  NUM_READ  registered busy flag of the captured address.
- BusyCount  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset:
  - Reset_n low asynchronously clears all registers, all busy bits, ReadData, ReadBusy and BusyCount to 0.
  - This applies in both the posedge and negedge processes.
  - Reset asserted mid-operation discards any write or reservation in flight.
  - The first edge after release behaves normally.
- Write (posedge):
  - If RegWrite=1, WriteRegister < DEPTH, and not (ZERO_REG=1 and WriteRegister=0): the register is loaded with WriteData and its busy bit is cleared.
  - Any other write is ignored.
- Reserve (posedge):
  - Under the same address legality rule as writes, Reserve=1 sets the busy bit of ReserveRegister.
  - Reserving an already-busy register leaves it busy, with no count change.
- Write and reserve to the same register in the same cycle:
  - Data is updated.
  - The busy bit ends at 1: a new producer takes ownership.
- BusyCount (posedge) tracks the number of set busy bits exactly:
  - +1 for each 0->1 transition.
  - -1 for each 1->0 transition.
  - A simultaneous set and clear on different registers nets to 0.
  - Range 0..DEPTH; never wraps.
- Read (negedge), for each port k independently:
  - If ReadEnable[k]=1, ReadData[k] takes the current register contents of ReadRegister[k] and ReadBusy[k] takes its busy bit.
  - If ReadEnable[k]=0, both hold their previous values.
  - Address >= DEPTH, or address 0 with ZERO_REG=1: captures data 0, busy 0.
- Latency:
  - A write at posedge N is visible on a read captured at the negedge immediately after N (half cycle).
  - No combinational path exists from any input to ReadData or ReadBusy.
- Port independence:
  - Multiple ports may read the same address in the same cycle and receive identical values.
- Hold-off:
  - Register contents change only at posedge, so they are stable for the half cycle before every capture edge.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse Reset_n low between edges -> ReadData, ReadBusy and BusyCount drop to 0 immediately; a later read of r5 returns 0.
- Write/read latency: posedge write r7=0x12345678; ports 0 and 1 both read r7 with enable -> both capture 0x12345678 at the next negedge; ReadBusy=0.
- Zero register (ZERO_REG=1): write r0=0xFFFFFFFF and reserve r0 -> reads of r0 return 0, ReadBusy=0, BusyCount=0.
- Scoreboard:
  - Reserve r3, then r4 -> BusyCount 1, then 2; a read of r3 shows ReadBusy=1.
  - Write r3=0xA5 -> busy cleared, BusyCount=1.
  - Same-cycle write and reserve of r4 -> data updated, busy stays 1, BusyCount stays 1.
- Enable hold and range: read r2=0x55 on port 1, deassert ReadEnable[1], write r2=0x66 -> port 1 holds 0x55. With DEPTH=24, read address 30 -> 0; a write to address 30 is ignored.
- Saturation: reserve all DEPTH registers (ZERO_REG=0) -> BusyCount=DEPTH; writing each clears it back to 0 with no wrap.

Source files
------------

// File: rtl/multiport_register_file_if.sv
// multiport_register_file_if: write/reserve/read bus for the multiport register file.
interface multiport_register_file_if #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);
    logic                       RegWrite;
    logic [ADDR_W-1:0]          WriteRegister;
    logic [WIDTH-1:0]           WriteData;
    logic                       Reserve;
    logic [ADDR_W-1:0]          ReserveRegister;
    logic [NUM_READ*ADDR_W-1:0] ReadRegister;
    logic [NUM_READ-1:0]        ReadEnable;
    logic [NUM_READ*WIDTH-1:0]  ReadData;
    logic [NUM_READ-1:0]        ReadBusy;
    logic [ADDR_W:0]            BusyCount;

    modport master (
        output RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister, ReadRegister, ReadEnable,
        input  ReadData, ReadBusy, BusyCount
    );
    modport slave (
        input  RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister, ReadRegister, ReadEnable,
        output ReadData, ReadBusy, BusyCount
    );
endinterface

// File: rtl/multiport_register_file.sv
// multiport_register_file: parametrised register file with NUM_READ negedge-captured read ports
// and a per-register pending-write scoreboard for RAW hazard detection.
module multiport_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input logic                    Clk,
    input logic                    Reset_n,
    multiport_register_file_if.slave bus
);
    logic [DEPTH-1:0][WIDTH-1:0]  regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d, we, rs;
    logic [ADDR_W:0]              count_q, count_d;
    logic [NUM_READ*WIDTH-1:0]    rd_q, rd_d;
    logic [NUM_READ-1:0]          rb_q, rb_d;

    // Row 0 never matches when hardwired to zero, so it stays at its reset value.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            we[i]     = bus.RegWrite && bus.WriteRegister == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0);
            rs[i]     = bus.Reserve && bus.ReserveRegister == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0);
            busy_d[i] = rs[i] | (busy_q[i] & ~we[i]);
            regs_d[i] = we[i] ? bus.WriteData : regs_q[i];
        end
        count_d = (ADDR_W+1)'($countones(busy_d));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q  <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Addresses at or beyond DEPTH match no row and capture zero.
    always_comb begin
        rd_d = rd_q;
        rb_d = rb_q;
        for (int k = 0; k < NUM_READ; k++) begin
            if (bus.ReadEnable[k]) begin
                rd_d[k*WIDTH +: WIDTH] = '0;
                rb_d[k]                = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.ReadRegister[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                        rd_d[k*WIDTH +: WIDTH] = regs_q[i];
                        rb_d[k]                = busy_q[i];
                    end
                end
            end
        end
    end

    always_ff @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_q <= '0;
            rb_q <= '0;
        end else begin
            rd_q <= rd_d;
            rb_q <= rb_d;
        end
    end

    assign bus.ReadData  = rd_q;
    assign bus.ReadBusy  = rb_q;
    assign bus.BusyCount = count_q;
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: drives two configurations (32 deep with zero register, 24 deep without)
// with identical stimulus and compares every capture against a behavioural scoreboard.
module tb_multiport_register_file;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic        reserve = 1'b0;
    logic [4:0]  reserve_reg = '0;
    logic [9:0]  read_reg = '0;
    logic [1:0]  read_en = '0;

    always #5 Clk = ~Clk;

    multiport_register_file_if #(.WIDTH(32), .ADDR_W(5), .NUM_READ(2)) b0 ();
    multiport_register_file_if #(.WIDTH(32), .ADDR_W(5), .NUM_READ(2)) b1 ();

    assign b0.RegWrite = reg_write;        assign b1.RegWrite = reg_write;
    assign b0.WriteRegister = write_reg;   assign b1.WriteRegister = write_reg;
    assign b0.WriteData = write_data;      assign b1.WriteData = write_data;
    assign b0.Reserve = reserve;           assign b1.Reserve = reserve;
    assign b0.ReserveRegister = reserve_reg; assign b1.ReserveRegister = reserve_reg;
    assign b0.ReadRegister = read_reg;     assign b1.ReadRegister = read_reg;
    assign b0.ReadEnable = read_en;        assign b1.ReadEnable = read_en;

    multiport_register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b0));
    multiport_register_file #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(0)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b1));

    logic [63:0] got_rd [2];
    logic [1:0]  got_rb [2];
    logic [5:0]  got_cnt [2];
    assign got_rd[0] = b0.ReadData;   assign got_rd[1] = b1.ReadData;
    assign got_rb[0] = b0.ReadBusy;   assign got_rb[1] = b1.ReadBusy;
    assign got_cnt[0] = b0.BusyCount; assign got_cnt[1] = b1.BusyCount;

    typedef struct packed {
        logic [1:0][1:0][31:0] data;
        logic [1:0][1:0]       busy;
        logic [1:0][5:0]       cnt;
    } exp_t;
    exp_t exp_q[$];

    int          depth [2] = '{32, 24};
    int          zr [2]    = '{1, 0};
    logic [31:0] m_reg [2][32];
    logic        m_busy [2][32];
    logic [31:0] p_data [2][2];
    logic        p_busy [2][2];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit legal(input int d, input int a);
        return a < depth[d] && !(zr[d] != 0 && a == 0);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[d][i]  = '0;
                m_busy[d][i] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                p_data[d][k] = '0;
                p_busy[d][k] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic w, input int wa, input logic [31:0] wd, input logic r, input int ra,
                        input int a0, input int a1, input logic [1:0] en);
        exp_t e;
        int   addr [2];
        int   c;
        reg_write = w; write_reg = 5'(wa); write_data = wd;
        reserve = r; reserve_reg = 5'(ra);
        read_reg = {5'(a1), 5'(a0)}; read_en = en;
        addr[0] = a0; addr[1] = a1;
        for (int d = 0; d < 2; d++) begin
            if (w && legal(d, wa)) begin
                m_reg[d][wa]  = wd;
                m_busy[d][wa] = 1'b0;
            end
            if (r && legal(d, ra)) m_busy[d][ra] = 1'b1;
            c = 0;
            for (int i = 0; i < 32; i++) c += int'(m_busy[d][i]);
            e.cnt[d] = 6'(c);
            for (int k = 0; k < 2; k++) begin
                if (en[k]) begin
                    p_data[d][k] = legal(d, addr[k]) ? m_reg[d][addr[k]] : 32'h0;
                    p_busy[d][k] = legal(d, addr[k]) ? m_busy[d][addr[k]] : 1'b0;
                end
                e.data[d][k] = p_data[d][k];
                e.busy[d][k] = p_busy[d][k];
            end
        end
        exp_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        e = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.data%0d", d, k), 64'(got_rd[d][k*32 +: 32]), 64'(e.data[d][k]));
                check($sformatf("u%0d.busy%0d", d, k), 64'(got_rb[d][k]), 64'(e.busy[d][k]));
            end
            check($sformatf("u%0d.count", d), 64'(got_cnt[d]), 64'(e.cnt[d]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.u%0d.data", tag, d), got_rd[d], 64'h0);
            check($sformatf("%s.u%0d.busy", tag, d), 64'(got_rb[d]), 64'h0);
            check($sformatf("%s.u%0d.count", tag, d), 64'(got_cnt[d]), 64'h0);
        end
    endtask

    // Reset lands between edges and is held across a posedge carrying a write and reservation.
    task automatic reset_pulse();
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h99999999;
        reserve = 1'b1; reserve_reg = 5'd9;
        Reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge Clk);
        #1;
        check_zero("rst_hold");
        Reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        model_clear();
        #3;
        check_zero("por");
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
        step(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 2'b11);
        reset_pulse();
        step(0, 0, 0, 0, 0, 5, 9, 2'b11);
        step(1, 7, 32'h12345678, 0, 0, 7, 7, 2'b11);
        step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 2'b11);
        step(1, 0, 32'h0, 0, 0, 0, 7, 2'b11);
        step(0, 0, 0, 1, 3, 3, 3, 2'b11);
        step(0, 0, 0, 1, 4, 3, 4, 2'b11);
        step(1, 3, 32'hA5, 0, 0, 3, 4, 2'b11);
        step(1, 4, 32'h77, 1, 4, 4, 3, 2'b11);
        step(1, 4, 32'h88, 1, 3, 3, 4, 2'b11);
        step(1, 2, 32'h55, 0, 0, 0, 2, 2'b10);
        step(1, 2, 32'h66, 0, 0, 0, 2, 2'b00);
        step(0, 0, 0, 0, 0, 2, 2, 2'b01);
        step(0, 0, 0, 0, 0, 0, 2, 2'b10);
        step(1, 30, 32'hCAFE, 0, 0, 30, 30, 2'b11);
        step(0, 0, 0, 1, 30, 30, 23, 2'b11);
        for (int i = 0; i < 24; i++) step(0, 0, 0, 1, i, i, 23 - i, 2'b11);
        step(0, 0, 0, 1, 5, 5, 0, 2'b11);
        for (int i = 0; i < 32; i++) step(1, i, 32'(i * 3 + 1), 0, 0, i, 31 - i, 2'b11);
        step(0, 0, 0, 0, 0, 23, 24, 2'b11);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
